vape_multi_or_protection: RTL and testbench
===========================================

# vape_multi_or_protection

Parametrised, multi-region successor to the single-region VAPE output-protection monitor. It watches the CPU program counter, the CPU data bus and the DMA bus, and tracks one protected executable region (ER) guarding NUM_OR independently enabled output regions (ORs). Any access pattern that could forge ER output clears `exec`. The block also reports a sticky per-region violation vector and an abort cause code. It sits beside the other VRASED/APEX hardware monitors and feeds `exec` into the attestation flag.

## Interface
- AW, 16: address and pc width.
- NUM_OR, 4: number of output regions, 1..8.
- RESET_HANDLER, 0 (AW bits): pc value that marks a CPU reset.

- clk  in  1  system clock; all state updates on the rising edge.
- puc_rst  in  1  reset; synchronous and active-high.
- pc  in  AW  current CPU program counter.
- data_addr  in  AW  CPU data address.
- data_en  in  1  CPU data write strobe.
- dma_addr  in  AW  DMA address.
- dma_en  in  1  DMA access strobe.
- er_min, er_max  in  AW each  inclusive ER bounds.
- or_min, or_max  in  NUM_OR*AW each  packed inclusive OR bounds; region i occupies bits [i*AW +: AW].
- or_enable  in  NUM_OR  per-region enable.
- exec  out  1  registered; 1 means the ER output is currently trustworthy.
- or_violation  out  NUM_OR  sticky; records which regions were hit by the write that caused the last abort.
- abort_cause  out  3  registered code for the last transition to ABORT.

## Operation
- State machine with three states:
  - ABORT: the ER has not run, or has been invalidated.
  - RUN: the pc is inside the ER after a legal entry.
  - DONE: the ER has exited legally.
- `exec` is 1 in RUN and DONE only.
- `prev_pc` register holds the pc of the previous cycle. It resets to RESET_HANDLER.
- `in_er` means er_min <= pc <= er_max. `prev_in_er` is the same test applied to prev_pc.
- `hit[i]` = or_enable[i] and or_min[i] <= addr <= or_max[i]. It is evaluated separately for data_addr (CPU) and dma_addr (DMA).
- `cfg_bad` is asserted when any of the following holds:
  - er_min >= er_max;
  - or_enable == 0;
  - any enabled region has or_min >= or_max;
  - any enabled region overlaps the ER.
- Config snapshot:
  - er_min, er_max, or_min, or_max and or_enable are latched on every transition into RUN.
  - In RUN or DONE, any difference between the live inputs and the snapshot is a violation.
- Abort conditions, in priority order (first match sets abort_cause):
  - 1: pc == RESET_HANDLER.
  - 2: cfg_bad.
  - 3: dma_en with any DMA hit, in any state.
  - 4: data_en with any CPU hit while not in_er, in RUN/DONE.
  - 5: illegal ER entry or exit, in RUN/DONE. Either in_er and not prev_in_er and pc != er_min, or prev_in_er and not in_er and prev_pc != er_max.
  - 6: config differs from the snapshot, in RUN/DONE.
- On any abort:
  - next state is ABORT and exec <= 0;
  - abort_cause <= code;
  - or_violation <= hit vector of the offending bus for codes 3 and 4, zero otherwise.
- Legal transitions, applied only when no abort condition holds:
  - ABORT to RUN when pc == er_min.
  - RUN to DONE when prev_pc == er_max and not in_er.
  - DONE to RUN when pc == er_min (re-execution). exec stays 1.
  - Otherwise the state holds.
- Entering RUN from ABORT clears abort_cause to 0 and or_violation to 0.
- CPU writes into an OR while in_er are legal in every state.
- Aborts taken while already in ABORT still update abort_cause and or_violation.
- Arithmetic: all comparisons are unsigned over AW bits and use inclusive bounds. No wrap-around region is supported; such a region is caught by the min >= max check.

## Timing
- puc_rst = 1 at a clock edge sets:
  - state = ABORT, exec = 0, abort_cause = 0, or_violation = 0;
  - prev_pc = RESET_HANDLER;
  - the snapshot to zero.
- Reset overrides every other event in the same cycle, including a reset that arrives mid-RUN.
- Latency: inputs are sampled at edge N and the outputs reflect them after edge N. There is exactly one cycle from a condition to `exec`.
- Before the first edge, outputs must power up at the reset values: ABORT, exec 0.
- Simultaneous events resolve by the priority list. For example, pc == er_min together with a DMA hit gives ABORT with cause 3.
- No handshakes. All inputs are single-cycle, level-sampled.

## Test plan
- Reset, then pc = er_min (0xE000; ER = 0xE000..0xE0FF; OR0 = 0x0200..0x021F enabled) -> exec = 1 one cycle later, abort_cause = 0.
- In RUN, CPU write 0x0210 with pc = 0x8000 reached by a jump from er_max -> exec = 0, abort_cause = 4, or_violation = 0001. The jump from er_max first gives DONE, then the write aborts.
- In DONE, dma_en with dma_addr = 0x0205 -> exec = 0, abort_cause = 3, or_violation = 0001. Repeat with OR1 enabled at 0x0300..0x030F and dma_addr = 0x0300 -> or_violation = 0010.
- In RUN, pc jumps to 0xE050 from 0x9000 -> cause 5. Exiting from 0xE010 to 0x9000 -> cause 5.
- In RUN, change or_max[0] to 0x0220 -> cause 6. Set or_min = or_max -> cause 2 from any state.
- Mid-RUN, puc_rst = 1 together with a DMA hit -> all outputs zero, state ABORT. pc = RESET_HANDLER without puc_rst -> cause 1.

Source files
------------

// File: rtl/vape_multi_or_protection_if.sv
// Monitored CPU/DMA buses, ER/OR configuration and protection results for vape_multi_or_protection.
// Plain level signals sampled every clock; there is no handshake.
interface vape_multi_or_protection_if #(
   parameter int AW     = 16,
   parameter int NUM_OR = 4
);
   logic [AW-1:0]        pc;
   logic [AW-1:0]        data_addr;
   logic                 data_en;
   logic [AW-1:0]        dma_addr;
   logic                 dma_en;
   logic [AW-1:0]        er_min;
   logic [AW-1:0]        er_max;
   logic [NUM_OR*AW-1:0] or_min;
   logic [NUM_OR*AW-1:0] or_max;
   logic [NUM_OR-1:0]    or_enable;
   logic                 exec;
   logic [NUM_OR-1:0]    or_violation;
   logic [2:0]           abort_cause;

   modport master (
      output pc, data_addr, data_en, dma_addr, dma_en,
      output er_min, er_max, or_min, or_max, or_enable,
      input  exec, or_violation, abort_cause
   );

   modport slave (
      input  pc, data_addr, data_en, dma_addr, dma_en,
      input  er_min, er_max, or_min, or_max, or_enable,
      output exec, or_violation, abort_cause
   );
endinterface

// File: rtl/vape_multi_or_protection.sv
// Multi-region VAPE output protection: clears exec on any access that could forge ER output.
// One cycle from sampled inputs to exec/abort_cause/or_violation; no backpressure (pure monitor).
module vape_multi_or_protection #(
   parameter int              AW            = 16,
   parameter int              NUM_OR        = 4,
   parameter logic [AW-1:0]   RESET_HANDLER = '0
) (
   input  logic                        clk,
   input  logic                        puc_rst,
   vape_multi_or_protection_if.slave   bus
);

   typedef enum logic [1:0] {ST_ABORT, ST_RUN, ST_DONE} state_t;

   state_t                state_q = ST_ABORT;
   state_t                state_d;
   logic [AW-1:0]         prev_pc_q = RESET_HANDLER;
   logic [2:0]            cause_q = '0;
   logic [2:0]            cause_d;
   logic [NUM_OR-1:0]     viol_q = '0;
   logic [NUM_OR-1:0]     viol_d;
   logic                  snap_ld;

   logic [AW-1:0]         snap_er_min, snap_er_max;
   logic [NUM_OR*AW-1:0]  snap_or_min, snap_or_max;
   logic [NUM_OR-1:0]     snap_or_en;

   logic [NUM_OR-1:0]     cpu_hit, dma_hit, reg_bad;
   logic                  in_er, prev_in_er, active;
   logic                  cfg_bad, cfg_diff, bad_edge;

   assign in_er      = (bus.pc >= bus.er_min) && (bus.pc <= bus.er_max);
   assign prev_in_er = (prev_pc_q >= bus.er_min) && (prev_pc_q <= bus.er_max);
   assign active     = (state_q != ST_ABORT);

   for (genvar i = 0; i < NUM_OR; i++) begin : g_or
      logic [AW-1:0] lo, hi;
      assign lo = bus.or_min[i*AW +: AW];
      assign hi = bus.or_max[i*AW +: AW];
      assign cpu_hit[i] = bus.or_enable[i] && (bus.data_addr >= lo) && (bus.data_addr <= hi);
      assign dma_hit[i] = bus.or_enable[i] && (bus.dma_addr >= lo) && (bus.dma_addr <= hi);
      // Inverted bounds or any overlap with the ER make the region untrustworthy.
      assign reg_bad[i] = bus.or_enable[i] &&
                          ((lo >= hi) || ((lo <= bus.er_max) && (bus.er_min <= hi)));
   end

   assign cfg_bad  = (bus.er_min >= bus.er_max) || (bus.or_enable == '0) || (|reg_bad);
   assign cfg_diff = (bus.er_min != snap_er_min) || (bus.er_max != snap_er_max) ||
                     (bus.or_min != snap_or_min) || (bus.or_max != snap_or_max) ||
                     (bus.or_enable != snap_or_en);
   assign bad_edge = (in_er && !prev_in_er && (bus.pc != bus.er_min)) ||
                     (prev_in_er && !in_er && (prev_pc_q != bus.er_max));

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      viol_d  = viol_q;
      snap_ld = 1'b0;
      if (bus.pc == RESET_HANDLER) begin
         state_d = ST_ABORT; cause_d = 3'd1; viol_d = '0;
      end else if (cfg_bad) begin
         state_d = ST_ABORT; cause_d = 3'd2; viol_d = '0;
      end else if (bus.dma_en && (|dma_hit)) begin
         state_d = ST_ABORT; cause_d = 3'd3; viol_d = dma_hit;
      end else if (active && bus.data_en && (|cpu_hit) && !in_er) begin
         state_d = ST_ABORT; cause_d = 3'd4; viol_d = cpu_hit;
      end else if (active && bad_edge) begin
         state_d = ST_ABORT; cause_d = 3'd5; viol_d = '0;
      end else if (active && cfg_diff) begin
         state_d = ST_ABORT; cause_d = 3'd6; viol_d = '0;
      end else begin
         case (state_q)
            ST_ABORT: if (bus.pc == bus.er_min) begin
               state_d = ST_RUN; cause_d = '0; viol_d = '0; snap_ld = 1'b1;
            end
            ST_RUN: if ((prev_pc_q == bus.er_max) && !in_er) state_d = ST_DONE;
            ST_DONE: if (bus.pc == bus.er_min) begin
               state_d = ST_RUN; snap_ld = 1'b1;
            end
            default: state_d = ST_ABORT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (puc_rst) begin
         state_q     <= ST_ABORT;
         prev_pc_q   <= RESET_HANDLER;
         cause_q     <= '0;
         viol_q      <= '0;
         snap_er_min <= '0;
         snap_er_max <= '0;
         snap_or_min <= '0;
         snap_or_max <= '0;
         snap_or_en  <= '0;
      end else begin
         state_q   <= state_d;
         prev_pc_q <= bus.pc;
         cause_q   <= cause_d;
         viol_q    <= viol_d;
         if (snap_ld) begin
            snap_er_min <= bus.er_min;
            snap_er_max <= bus.er_max;
            snap_or_min <= bus.or_min;
            snap_or_max <= bus.or_max;
            snap_or_en  <= bus.or_enable;
         end
      end
   end

   assign bus.exec         = (state_q != ST_ABORT);
   assign bus.abort_cause  = cause_q;
   assign bus.or_violation = viol_q;

endmodule

// File: tb/tb_vape_multi_or_protection.sv
// Directed scoreboard bench for vape_multi_or_protection: expectations queued per cycle, checked on the falling edge.
module tb_vape_multi_or_protection;
   logic clk = 1'b0;
   logic puc_rst;

   vape_multi_or_protection_if #(.AW(16), .NUM_OR(4)) vif ();

   vape_multi_or_protection #(.AW(16), .NUM_OR(4), .RESET_HANDLER(16'h0000)) dut (
      .clk     (clk),
      .puc_rst (puc_rst),
      .bus     (vif)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];
   string      name_q[$];

   function automatic logic [7:0] observed();
      return {vif.exec, vif.abort_cause, vif.or_violation};
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [7:0] e, g;
         string      n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         g = observed();
         tests++;
         if (g !== e) begin
            fails++;
            $display("FAIL %s: got exec=%0d cause=%0d viol=%b, expected exec=%0d cause=%0d viol=%b",
                     n, g[7], g[6:4], g[3:0], e[7], e[6:4], e[3:0]);
         end
      end
   end

   task automatic cyc(input bit e_exec, input logic [2:0] e_cause, input logic [3:0] e_viol,
                      input string nm);
      @(posedge clk);
      exp_q.push_back({e_exec, e_cause, e_viol});
      name_q.push_back(nm);
      #1;
   endtask

   task automatic set_or(input int i, input logic [15:0] lo, input logic [15:0] hi);
      vif.or_min[i*16 +: 16] = lo;
      vif.or_max[i*16 +: 16] = hi;
   endtask

   initial begin
      puc_rst       = 1'b1;
      vif.pc        = 16'h4000;
      vif.data_addr = 16'h0000;
      vif.data_en   = 1'b0;
      vif.dma_addr  = 16'h0000;
      vif.dma_en    = 1'b0;
      vif.er_min    = 16'hE000;
      vif.er_max    = 16'hE0FF;
      vif.or_min    = '0;
      vif.or_max    = '0;
      vif.or_enable = 4'b0001;
      set_or(0, 16'h0200, 16'h021F);

      #1;
      tests++;
      if (observed() !== 8'h00) begin
         fails++;
         $display("FAIL power_up: got %h, expected 00", observed());
      end

      cyc(0, 0, 4'b0000, "reset");
      puc_rst = 1'b0;
      vif.pc = 16'h4000; cyc(0, 0, 4'b0000, "idle_abort");
      vif.pc = 16'hE000; cyc(1, 0, 4'b0000, "enter_run");
      vif.pc = 16'hE001; cyc(1, 0, 4'b0000, "run_step");
      vif.pc = 16'hE0FF; cyc(1, 0, 4'b0000, "run_at_max");
      vif.pc = 16'h8000; cyc(1, 0, 4'b0000, "legal_exit_done");
      vif.data_en = 1'b1; vif.data_addr = 16'h0210;
      cyc(0, 4, 4'b0001, "cpu_write_or0");
      vif.data_en = 1'b0; vif.pc = 16'h8004;
      cyc(0, 4, 4'b0001, "cause4_sticky");

      vif.pc = 16'hE000; cyc(1, 0, 4'b0000, "reenter_clears");
      vif.pc = 16'hE0FF; cyc(1, 0, 4'b0000, "run_max2");
      vif.pc = 16'h8000; cyc(1, 0, 4'b0000, "done2");
      vif.dma_en = 1'b1; vif.dma_addr = 16'h0205;
      cyc(0, 3, 4'b0001, "dma_or0_done");
      vif.dma_en = 1'b0;

      set_or(1, 16'h0300, 16'h030F); vif.or_enable = 4'b0011;
      vif.pc = 16'h4000; cyc(0, 3, 4'b0001, "cfg_change_in_abort");
      vif.pc = 16'hE000; cyc(1, 0, 4'b0000, "enter_run_or1");
      vif.pc = 16'hE0FF; cyc(1, 0, 4'b0000, "run_max3");
      vif.pc = 16'h8000; cyc(1, 0, 4'b0000, "done3");
      vif.dma_en = 1'b1; vif.dma_addr = 16'h0300;
      cyc(0, 3, 4'b0010, "dma_or1_done");
      vif.dma_en = 1'b0;

      vif.pc = 16'hE000; cyc(1, 0, 4'b0000, "enter_run4");
      vif.pc = 16'hE010; vif.data_en = 1'b1; vif.data_addr = 16'h0200;
      cyc(1, 0, 4'b0000, "in_er_write_legal");
      vif.data_en = 1'b0;
      vif.pc = 16'h9000; cyc(0, 5, 4'b0000, "illegal_exit");

      vif.pc = 16'hE000; cyc(1, 0, 4'b0000, "enter_run5");
      vif.pc = 16'hE0FF; cyc(1, 0, 4'b0000, "run_max5");
      vif.pc = 16'h9000; cyc(1, 0, 4'b0000, "done5");
      vif.pc = 16'hE050; cyc(0, 5, 4'b0000, "illegal_entry");
      vif.pc = 16'hE051; cyc(0, 5, 4'b0000, "abort_mid_er_holds");

      vif.pc = 16'h9000; cyc(0, 5, 4'b0000, "leave_er_abort");
      vif.pc = 16'hE000; cyc(1, 0, 4'b0000, "enter_run6");
      vif.pc = 16'hE001; set_or(0, 16'h0200, 16'h0220);
      cyc(0, 6, 4'b0000, "cfg_diff");
      set_or(0, 16'h0200, 16'h021F);
      vif.pc = 16'h9000; cyc(0, 6, 4'b0000, "cause6_sticky");

      set_or(0, 16'h021F, 16'h021F);
      cyc(0, 2, 4'b0000, "min_eq_max_abort");
      set_or(0, 16'h0200, 16'h021F);
      vif.pc = 16'hE000; cyc(1, 0, 4'b0000, "enter_run7");
      vif.pc = 16'hE001; set_or(1, 16'h0300, 16'h0300);
      cyc(0, 2, 4'b0000, "min_eq_max_run");
      set_or(1, 16'h0300, 16'h030F);
      vif.pc = 16'h9000; cyc(0, 2, 4'b0000, "cause2_sticky");

      vif.pc = 16'hE000; vif.dma_en = 1'b1; vif.dma_addr = 16'h0205;
      cyc(0, 3, 4'b0001, "entry_with_dma_hit");
      vif.dma_en = 1'b0;

      vif.pc = 16'hE000; cyc(1, 0, 4'b0000, "enter_run8");
      puc_rst = 1'b1; vif.pc = 16'hE001; vif.dma_en = 1'b1;
      cyc(0, 0, 4'b0000, "reset_mid_run");
      puc_rst = 1'b0; vif.dma_en = 1'b0; vif.pc = 16'h4000;
      cyc(0, 0, 4'b0000, "after_reset");

      vif.pc = 16'hE000; cyc(1, 0, 4'b0000, "enter_run9");
      vif.pc = 16'h0000; cyc(0, 1, 4'b0000, "pc_reset_handler");

      vif.pc = 16'h4000; vif.or_enable = 4'b0000;
      cyc(0, 2, 4'b0000, "no_region_enabled");
      vif.or_enable = 4'b0011;
      set_or(1, 16'hE0F0, 16'hE10F);
      cyc(0, 2, 4'b0000, "or_overlaps_er");
      set_or(1, 16'h0300, 16'h030F);
      vif.pc = 16'hE000; cyc(1, 0, 4'b0000, "final_entry");

      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
      #6;
      if (exp_q.size() > 0) begin
         fails++;
         $display("FAIL drain_timeout: %0d checks pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
